fetch_decode_ctrl: RTL and testbench
====================================

Name: fetch_decode_ctrl

Overview:
- Control stage directly upstream of the register-file/ALU datapath.
- Holds the program counter and fetches 20-bit instructions from an asynchronous-read instruction memory.
- Latches each instruction into an instruction register, then decodes it into register addresses, immediate, ALU select and write enable for the datapath.
- Uses the datapath's Zero flag to resolve BEQ. Runs a 2-cycle FETCH/EXEC loop per instruction, with IDLE and HALT states.

Parameters:
- PC_W, 8, program counter and instruction address width.
- INSTR_W, 20, instruction width; fixed format below, other values unsupported.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  leaves IDLE; sampled only in IDLE.
- instr_data  input  INSTR_W  instruction memory read data; combinational from instr_addr.
- Zero  input  1  ALU zero flag from datapath; same cycle.
- instr_addr  output  PC_W  instruction memory address; equals pc.
- pc  output  PC_W  current program counter.
- RA1  output  4  datapath read address A.
- RA2  output  4  datapath read address B.
- WA  output  4  datapath write address.
- immediate  output  8  datapath immediate.
- write_enable  output  1  register write strobe.
- ALUsrc  output  1  0 = RD2, 1 = immediate.
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- halted  output  1  high while in HALT.
- illegal  output  1  sticky; set on an undefined opcode.

Behaviour:
- Clock is CLK. Reset is synchronous, active-high on RST.
- Reset values: state=IDLE, pc=0, IR=0, halted=0, illegal=0. All decode outputs are 0. RST overrides every other event in the same cycle, including mid-EXEC, so no write_enable pulse occurs in that cycle.
- Instruction format: op=IR[19:16], rd=IR[15:12], ra=IR[11:8], rb=IR[7:4], imm8=IR[7:0], off4=IR[3:0] (signed).
- IDLE: outputs 0. If start=1, go to FETCH. Otherwise stay.
- FETCH: instr_addr=pc. At the clock edge IR<=instr_data; go to EXEC. Decode outputs are 0.
- EXEC: decode outputs are driven combinationally from IR; pc updates at the end of the cycle. Next state is FETCH, except HALT.
- Decode outputs are forced to 0 in every state other than EXEC.
- op 0x0-0x3 ADD/SUB/AND/OR: RA1=ra, RA2=rb, WA=rd, ALUsrc=0, ALUControl=op[1:0], write_enable=1, pc<=pc+1.
- op 0x4-0x7 ADDI/SUBI/ANDI/ORI: RA1=ra, WA=rd, immediate=imm8, ALUsrc=1, ALUControl=op[1:0], write_enable=1, pc<=pc+1.
- op 0x8 BEQ: RA1=ra, RA2=rb, ALUControl=01, ALUsrc=0, write_enable=0.
  - If Zero=1: pc<=pc+sign_extend(off4), modulo 2^PC_W.
  - Otherwise: pc<=pc+1.
- op 0x9 JMP: pc<=imm8 (zero-extended/truncated to PC_W), write_enable=0.
- op 0xE NOP: pc<=pc+1.
- op 0xF HALT: pc unchanged; next state HALT.
- Any other opcode: treated as NOP; illegal<=1, which stays set until RST.
- HALT: halted=1, outputs 0, pc frozen, start ignored. Only RST exits.
- pc arithmetic wraps modulo 2^PC_W: 0xFF+1 -> 0x00; BEQ offset -1 from 0x00 -> 0xFF.
- BEQ with off4=0 re-executes itself; this is legal and not detected.
- write_enable is high for exactly one cycle per ALU/immediate instruction, and never two cycles in a row.
- Throughput: one instruction per 2 cycles. Writeback happens at the EXEC clock edge, so the next instruction reads the updated register.

Test Plan:
- Reset/idle: RST=1 for 2 cycles, start=0 for 5 cycles -> pc=0, all decode outputs 0, halted=0, instr_addr stays 0.
- ADDI then ADD: mem[0]=0x4_1_0_05 (r1=r0+5), mem[1]=0x0_2_1_10 (r2=r1+r1), start pulse.
  - EXEC of mem[0]: WA=1, RA1=0, immediate=0x05, ALUsrc=1, ALUControl=00, write_enable=1.
  - EXEC of mem[1]: RA1=1, RA2=1, WA=2, ALUsrc=0.
  - pc reaches 2 on the 5th cycle after start.
- BEQ taken and not taken: at pc=4, BEQ off4=0xE (-2).
  - With Zero=1: next pc=2.
  - With Zero=0: next pc=5.
  - write_enable=0 and ALUControl=01 in both cases.
- JMP and wrap: JMP 0xFF then NOP at 0xFF -> pc goes 0xFF then 0x00.
- HALT and illegal: mem[0]=0xA0000, mem[1]=0xF0000.
  - illegal=1 after the first EXEC.
  - halted=1 with pc=1 frozen for 10 cycles; start=1 has no effect.
  - RST clears halted and illegal and returns pc to 0.
- Reset mid-EXEC: assert RST during the EXEC of an ADD -> write_enable=0 in that cycle, next state IDLE, pc=0.

Source files
------------

// File: rtl/fetch_decode_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_decode_ctrl_if
// Bundle of signals between the fetch/decode controller, its instruction
// memory and the register-file/ALU datapath.
//   master : the controller (drives pc/address and decode outputs)
//   slave  : the environment (drives start, memory read data, Zero flag)
// Signals:
//   start        leaves IDLE (sampled only in IDLE)
//   instr_data   instruction memory read data, combinational from instr_addr
//   Zero         ALU zero flag, same cycle
//   instr_addr   instruction memory address (equals pc)
//   pc           current program counter
//   RA1/RA2/WA   datapath read/write register addresses
//   immediate    datapath immediate operand
//   write_enable register write strobe
//   ALUsrc       0 = RD2, 1 = immediate
//   ALUControl   00 ADD, 01 SUB, 10 AND, 11 OR
//   halted       high while in HALT
//   illegal      sticky undefined-opcode flag
// ---------------------------------------------------------------------------
interface fetch_decode_ctrl_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 20
);
  logic               start;
  logic [INSTR_W-1:0] instr_data;
  logic               Zero;
  logic [PC_W-1:0]    instr_addr;
  logic [PC_W-1:0]    pc;
  logic [3:0]         RA1;
  logic [3:0]         RA2;
  logic [3:0]         WA;
  logic [7:0]         immediate;
  logic               write_enable;
  logic               ALUsrc;
  logic [1:0]         ALUControl;
  logic               halted;
  logic               illegal;

  modport master (
    input  start, instr_data, Zero,
    output instr_addr, pc, RA1, RA2, WA, immediate,
           write_enable, ALUsrc, ALUControl, halted, illegal
  );

  modport slave (
    output start, instr_data, Zero,
    input  instr_addr, pc, RA1, RA2, WA, immediate,
           write_enable, ALUsrc, ALUControl, halted, illegal
  );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_decode_ctrl
// Program counter, instruction register and decoder feeding the
// register-file/ALU datapath. Each instruction takes two cycles: FETCH
// latches the instruction, EXEC drives the decode outputs and updates pc.
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous active-high reset
//   bus  fetch_decode_ctrl_if.master (memory, datapath and status signals)
// Instruction fields: op=[19:16] rd=[15:12] ra=[11:8] rb=[7:4]
//                     imm8=[7:0] off4=[3:0] (signed)
// ---------------------------------------------------------------------------
module fetch_decode_ctrl #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 20
) (
  input  logic                 CLK,
  input  logic                 RST,
  fetch_decode_ctrl_if.master  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_SUBI = 4'h5;
  localparam logic [3:0] OP_ANDI = 4'h6;
  localparam logic [3:0] OP_ORI  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  // Branch offsets are 4-bit two's complement; widen to pc width.
  function automatic logic [PC_W-1:0] sext_off4(input logic [3:0] off);
    sext_off4 = {{(PC_W-4){off[3]}}, off};
  endfunction

  logic [1:0]         r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               r_halted;
  logic               r_illegal;

  logic [1:0]         w_state_next;
  logic [PC_W-1:0]    w_pc_next;
  logic               w_set_illegal;
  logic [3:0]         w_ra1;
  logic [3:0]         w_ra2;
  logic [3:0]         w_wa;
  logic [7:0]         w_imm;
  logic               w_we;
  logic               w_src;
  logic [1:0]         w_alu;

  logic [3:0]         w_op;
  logic [3:0]         w_rd;
  logic [3:0]         w_ra;
  logic [3:0]         w_rb;
  logic [7:0]         w_imm8;

  assign w_op   = r_ir[19:16];
  assign w_rd   = r_ir[15:12];
  assign w_ra   = r_ir[11:8];
  assign w_rb   = r_ir[7:4];
  assign w_imm8 = r_ir[7:0];

  // Next-state, next-pc and decode outputs; decode is non-zero only in EXEC.
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_set_illegal = 1'b0;
    w_ra1         = 4'd0;
    w_ra2         = 4'd0;
    w_wa          = 4'd0;
    w_imm         = 8'd0;
    w_we          = 1'b0;
    w_src         = 1'b0;
    w_alu         = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_FETCH: begin
        w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_next = ST_FETCH;
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_ra1     = w_ra;
            w_ra2     = w_rb;
            w_wa      = w_rd;
            w_src     = 1'b0;
            w_alu     = w_op[1:0];
            w_we      = 1'b1;
            w_pc_next = r_pc + PC_ONE;
          end
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
            w_ra1     = w_ra;
            w_wa      = w_rd;
            w_imm     = w_imm8;
            w_src     = 1'b1;
            w_alu     = w_op[1:0];
            w_we      = 1'b1;
            w_pc_next = r_pc + PC_ONE;
          end
          OP_BEQ: begin
            // Comparison is a SUB in the datapath; Zero arrives this cycle.
            w_ra1 = w_ra;
            w_ra2 = w_rb;
            w_alu = 2'b01;
            if (bus.Zero) begin
              w_pc_next = r_pc + sext_off4(r_ir[3:0]);
            end else begin
              w_pc_next = r_pc + PC_ONE;
            end
          end
          OP_JMP: begin
            w_pc_next = PC_W'(w_imm8);
          end
          OP_NOP: begin
            w_pc_next = r_pc + PC_ONE;
          end
          OP_HALT: begin
            w_state_next = ST_HALT;
          end
          default: begin
            // Undefined opcode behaves as NOP and raises the sticky flag.
            w_set_illegal = 1'b1;
            w_pc_next     = r_pc + PC_ONE;
          end
        endcase
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, pc, instruction register and status flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_pc      <= {PC_W{1'b0}};
      r_ir      <= {INSTR_W{1'b0}};
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_halted <= (w_state_next == ST_HALT);
      if (r_state == ST_FETCH) begin
        r_ir <= bus.instr_data;
      end else begin
        r_ir <= r_ir;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end else begin
        r_illegal <= r_illegal;
      end
    end
  end

  assign bus.instr_addr   = r_pc;
  assign bus.pc           = r_pc;
  assign bus.RA1          = w_ra1;
  assign bus.RA2          = w_ra2;
  assign bus.WA           = w_wa;
  assign bus.immediate    = w_imm;
  // A reset arriving during EXEC must suppress the writeback of that cycle.
  assign bus.write_enable = w_we & ~RST;
  assign bus.ALUsrc       = w_src;
  assign bus.ALUControl   = w_alu;
  assign bus.halted       = r_halted;
  assign bus.illegal      = r_illegal;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_ctrl
// Directed bench for fetch_decode_ctrl: small instruction memory model,
// expected output snapshots pushed to a scoreboard queue and compared
// field by field one step later.
// ---------------------------------------------------------------------------
module tb_fetch_decode_ctrl;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  logic [19:0] mem [0:255];

  fetch_decode_ctrl_if #(.PC_W(8), .INSTR_W(20)) bus ();

  fetch_decode_ctrl #(.PC_W(8), .INSTR_W(20)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  assign bus.instr_data = mem[bus.instr_addr];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [7:0]  pc;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa;
    logic [7:0]  imm;
    logic        we;
    logic        src;
    logic [1:0]  alu;
    logic        hlt;
    logic        ill;
  } exp_t;

  exp_t sb [$];

  function automatic exp_t quiet(string tag, logic [7:0] pc, logic hlt, logic ill);
    exp_t e;
    e.tag = tag; e.pc = pc; e.ra1 = 4'd0; e.ra2 = 4'd0; e.wa = 4'd0;
    e.imm = 8'd0; e.we = 1'b0; e.src = 1'b0; e.alu = 2'b00;
    e.hlt = hlt; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t exec_e(string tag, logic [7:0] pc, logic [3:0] ra1,
                                  logic [3:0] ra2, logic [3:0] wa, logic [7:0] imm,
                                  logic we, logic src, logic [1:0] alu, logic ill);
    exp_t e;
    e = quiet(tag, pc, 1'b0, ill);
    e.ra1 = ra1; e.ra2 = ra2; e.wa = wa; e.imm = imm;
    e.we = we; e.src = src; e.alu = alu;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Push the expectation, let inputs settle, then pop and compare.
  task automatic check(exp_t e_in);
    exp_t e;
    sb.push_back(e_in);
    #1;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},      32'(bus.pc),           32'(e.pc));
      chk({e.tag, ".addr"},    32'(bus.instr_addr),   32'(e.pc));
      chk({e.tag, ".RA1"},     32'(bus.RA1),          32'(e.ra1));
      chk({e.tag, ".RA2"},     32'(bus.RA2),          32'(e.ra2));
      chk({e.tag, ".WA"},      32'(bus.WA),           32'(e.wa));
      chk({e.tag, ".imm"},     32'(bus.immediate),    32'(e.imm));
      chk({e.tag, ".we"},      32'(bus.write_enable), 32'(e.we));
      chk({e.tag, ".src"},     32'(bus.ALUsrc),       32'(e.src));
      chk({e.tag, ".alu"},     32'(bus.ALUControl),   32'(e.alu));
      chk({e.tag, ".halted"},  32'(bus.halted),       32'(e.hlt));
      chk({e.tag, ".illegal"}, 32'(bus.illegal),      32'(e.ill));
    end
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    bus.start = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic kick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 20'hF0000;
    RST       = 1'b1;
    bus.start = 1'b0;
    bus.Zero  = 1'b0;

    // Reset held two cycles, then idle with start low.
    tick();
    tick();
    check(quiet("rst", 8'h00, 1'b0, 1'b0));
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check(quiet("idle", 8'h00, 1'b0, 1'b0));
    end

    // ADDI r1=r0+5 then ADD r2=r1+r1, then HALT.
    mem[0] = 20'h41005;
    mem[1] = 20'h02110;
    mem[2] = 20'hF0000;
    do_reset();
    kick();
    check(quiet("addi_fetch", 8'h00, 1'b0, 1'b0));
    tick();
    check(exec_e("addi_exec", 8'h00, 4'd0, 4'd0, 4'd1, 8'h05, 1'b1, 1'b1, 2'b00, 1'b0));
    tick();
    check(quiet("add_fetch", 8'h01, 1'b0, 1'b0));
    tick();
    check(exec_e("add_exec", 8'h01, 4'd1, 4'd1, 4'd2, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0));
    tick();
    check(quiet("pc_two", 8'h02, 1'b0, 1'b0));
    tick();
    check(quiet("halt_exec", 8'h02, 1'b0, 1'b0));
    tick();
    check(quiet("halt_state", 8'h02, 1'b1, 1'b0));

    // BEQ at pc=4 with off4=-2: taken (Zero=1) and not taken (Zero=0).
    mem[0] = 20'h90004;
    mem[4] = 20'h8012E;
    mem[2] = 20'hF0000;
    mem[5] = 20'hF0000;
    bus.Zero = 1'b1;
    do_reset();
    kick();
    check(quiet("beqt_jmp_fetch", 8'h00, 1'b0, 1'b0));
    tick();
    check(quiet("beqt_jmp_exec", 8'h00, 1'b0, 1'b0));
    tick();
    check(quiet("beqt_fetch", 8'h04, 1'b0, 1'b0));
    tick();
    check(exec_e("beqt_exec", 8'h04, 4'd1, 4'd2, 4'd0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0));
    tick();
    check(quiet("beqt_target", 8'h02, 1'b0, 1'b0));

    bus.Zero = 1'b0;
    do_reset();
    kick();
    check(quiet("beqn_jmp_fetch", 8'h00, 1'b0, 1'b0));
    tick();
    check(quiet("beqn_jmp_exec", 8'h00, 1'b0, 1'b0));
    tick();
    check(quiet("beqn_fetch", 8'h04, 1'b0, 1'b0));
    tick();
    check(exec_e("beqn_exec", 8'h04, 4'd1, 4'd2, 4'd0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0));
    tick();
    check(quiet("beqn_next", 8'h05, 1'b0, 1'b0));

    // JMP 0xFF then NOP at 0xFF: pc wraps to 0x00.
    mem[0]   = 20'h900FF;
    mem[255] = 20'hE0000;
    do_reset();
    kick();
    check(quiet("jmp_fetch", 8'h00, 1'b0, 1'b0));
    tick();
    check(quiet("jmp_exec", 8'h00, 1'b0, 1'b0));
    tick();
    check(quiet("nop_fetch", 8'hFF, 1'b0, 1'b0));
    tick();
    check(quiet("nop_exec", 8'hFF, 1'b0, 1'b0));
    tick();
    check(quiet("wrap", 8'h00, 1'b0, 1'b0));

    // Undefined opcode then HALT; start ignored; reset clears flags.
    mem[0] = 20'hA0000;
    mem[1] = 20'hF0000;
    do_reset();
    kick();
    check(quiet("ill_fetch", 8'h00, 1'b0, 1'b0));
    tick();
    check(quiet("ill_exec", 8'h00, 1'b0, 1'b0));
    tick();
    check(quiet("ill_set", 8'h01, 1'b0, 1'b1));
    tick();
    check(quiet("hlt_exec", 8'h01, 1'b0, 1'b1));
    tick();
    check(quiet("hlt_enter", 8'h01, 1'b1, 1'b1));
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check(quiet("hlt_frozen", 8'h01, 1'b1, 1'b1));
    end
    bus.start = 1'b0;
    RST = 1'b1;
    tick();
    check(quiet("hlt_rst", 8'h00, 1'b0, 1'b0));
    RST = 1'b0;

    // Reset asserted during the EXEC of an ADD.
    mem[0] = 20'h03120;
    do_reset();
    kick();
    check(quiet("rx_fetch", 8'h00, 1'b0, 1'b0));
    tick();
    check(exec_e("rx_exec", 8'h00, 4'd1, 4'd2, 4'd3, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0));
    RST = 1'b1;
    #1;
    chk("rx_we_suppressed", 32'(bus.write_enable), 32'd0);
    tick();
    RST = 1'b0;
    check(quiet("rx_after", 8'h00, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check(quiet("rx_idle", 8'h00, 1'b0, 1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
